// File: rtl/lix_pipe_reg.sv
// Elastic valid/ready pipeline of D register stages with flush and occupancy count.
// Bubbles are squeezed out under back-pressure; o_cnt is the registered stage population.
module lix_pipe_reg #(
    parameter int unsigned W = 32,
    parameter int unsigned D = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   i_vld,
    input  logic [W-1:0]           i_x,
    output logic                   o_rdy,
    output logic                   o_vld,
    output logic [W-1:0]           o_z,
    input  logic                   i_rdy,
    input  logic                   i_flush,
    output logic [$clog2(D+1)-1:0] o_cnt
);
    localparam int unsigned CW = $clog2(D + 1);

    logic [D-1:0]  vld_q, vld_d;
    logic [W-1:0]  dat_q [D];
    logic [W-1:0]  src   [D];
    logic [D-1:0]  feed;
    logic [D-1:0]  load;
    logic [D:0]    stg_rdy;
    logic [CW-1:0] cnt_q, cnt_d;

    // Ready chain: a stage can take data if it is empty or everything ahead can move.
    always_comb begin
        stg_rdy[D] = i_rdy;
        for (int k = int'(D) - 1; k >= 0; k--) begin
            stg_rdy[k] = !vld_q[k] || stg_rdy[k+1];
        end
    end

    assign o_rdy = stg_rdy[0] && !i_flush;

    // Each stage is fed by the one behind it; stage 0 is fed by the upstream port.
    always_comb begin
        feed   = D'({vld_q, i_vld});
        src[0] = i_x;
        for (int k = 1; k < int'(D); k++) begin
            src[k] = dat_q[k-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        load  = '0;
        cnt_d = '0;
        for (int k = 0; k < int'(D); k++) begin
            if (i_flush) begin
                vld_d[k] = 1'b0;
            end else if (stg_rdy[k]) begin
                vld_d[k] = feed[k];
                load[k]  = feed[k];
            end
            cnt_d = cnt_d + CW'(vld_d[k]);
        end
    end

    // Data registers only move on a load, so a drained stage keeps its last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int k = 0; k < int'(D); k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < int'(D); k++) begin
                if (load[k]) begin
                    dat_q[k] <= src[k];
                end
            end
        end
    end

    assign o_vld = vld_q[D-1];
    assign o_z   = dat_q[D-1];
    assign o_cnt = cnt_q;

endmodule
